glip_host_bridge: RTL and testbench
===================================

// Module: glip_host_bridge
// PURPOSE
//  Single-clock host<->logic bridge for the GLIP debug link of the MPSoC testbench.
//  It buffers 16-bit words from a host-side stream into fifo_in (toward system logic).
//  It also buffers words from fifo_out (from system logic) toward the host.
//  Host control writes drive logic_rst (held system reset) and com_rst (one-cycle link flush).
// PARAMETERS
//  WIDTH      16  data word width of every channel
//  FIFO_DEPTH 8   entries per direction; power of two, >=2
// PORTS
//  clk              in   1      system clock
//  rst              in   1      synchronous active-high reset
//  host_in_data     in   WIDTH  host->logic word
//  host_in_valid    in   1      host word valid
//  host_in_ready    out  1      bridge accepts host word (= !in FIFO full)
//  host_out_data    out  WIDTH  logic->host word
//  host_out_valid   out  1      host_out_data valid (= !out FIFO empty)
//  host_out_ready   in   1      host consumes word
//  host_ctrl_valid  in   1      control write strobe
//  host_ctrl_data   in   2      [0] logic_rst level, [1] com_rst request
//  fifo_in_data     out  WIDTH  glip_channel fifo_in: word to system
//  fifo_in_valid    out  1      fifo_in valid
//  fifo_in_ready    in   1      system accepts word
//  fifo_out_data    in   WIDTH  glip_channel fifo_out: word from system
//  fifo_out_valid   in   1      system word valid
//  fifo_out_ready   out  1      bridge accepts system word (= !out FIFO full)
//  com_rst          out  1      one-cycle link reset pulse
//  logic_rst        out  1      held reset for system logic (OR'd with rst externally)
// BEHAVIOUR
//  - All state on rising clk. rst (sync): both FIFOs empty, host_out_valid=0, fifo_in_valid=0.
//    Also on rst: ready outputs=1, com_rst=0, logic_rst=0.
//  - Handshake: a transfer happens in a cycle where valid&&ready. Data is stable while valid&&!ready.
//  - FIFOs are first-word-fall-through.
//    A word pushed in cycle N is visible on the read side in cycle N+1.
//  - Full: ready=0. No push while full, even if a pop occurs in the same cycle.
//  - Empty: valid=0. A pop while empty is ignored.
//  - Simultaneous push and pop when not full and not empty: the count is unchanged.
//  - Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit.
//    full when addresses match and wrap bits differ.
//  - Ctrl write (host_ctrl_valid=1): logic_rst <= host_ctrl_data[0] and holds until the next write.
//    If host_ctrl_data[1]=1, com_rst=1 for exactly the next cycle. Both FIFOs are flushed in the same edge.
//    Any push in the flush cycle is discarded.
//  - Ctrl write and rst in the same cycle: rst wins.
//  - Word order is strictly preserved per direction; the two directions are independent.
// STRUCTURE
//  - Package glip_pkg: WIDTH default, ctrl bit index constants (CTRL_LOGIC_RST=0, CTRL_COM_RST=1).
//  - Sub-module glip_sync_fifo (WIDTH, DEPTH; push/pop/flush, data, full, empty), instantiated twice.
//  - The top level contains only the control register, the com_rst pulse and the wiring.
// TESTING
//  - Reset: assert rst 2 cycles.
//    -> host_in_ready=1, fifo_out_ready=1, fifo_in_valid=0, host_out_valid=0, logic_rst=0, com_rst=0.
//  - Host stream: push 0x1111,0x2222,0x3333 with fifo_in_ready=1.
//    -> fifo_in emits the same order; first word appears 1 cycle after its push.
//  - Full/backpressure: fifo_in_ready=0, push 9 words.
//    -> host_in_ready=0 after 8; 9th held. Release -> all 9 arrive in order, none lost or duplicated.
//  - Reverse path: system pushes 0xABCD,0x0001; toggle host_out_ready 1/0.
//    -> host receives 0xABCD then 0x0001 only on ready cycles.
//  - Control: write ctrl=2'b01 -> logic_rst=1 held.
//    Then write ctrl=2'b10 with 3 words queued -> com_rst one-cycle pulse, logic_rst=0, both FIFOs empty next cycle.
//  - Wrap-around: stream 100 random words with random ready on both sides.
//    -> output sequence equals input sequence.

Source files
------------

// File: rtl/glip_pkg.sv
// Shared constants and types for the GLIP host bridge.
// The bridge top and its stream interface both import this package.
package glip_pkg;

    localparam int GLIP_WIDTH      = 16;
    localparam int GLIP_FIFO_DEPTH = 8;

    // Bit positions inside a host control word
    localparam int CTRL_LOGIC_RST = 0;
    localparam int CTRL_COM_RST   = 1;
    localparam int CTRL_WIDTH     = 2;

    typedef struct packed {
        logic com_rst;    // bit CTRL_COM_RST
        logic logic_rst;  // bit CTRL_LOGIC_RST
    } ctrl_word_t;

    // Pointer width with the extra wrap bit that separates full from empty
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/glip_host_bridge_if.sv
// Host, system and control signals of the GLIP bridge in one bundle.
// The slave modport is the bridge itself; the master modport is its environment.
interface glip_host_bridge_if #(
    parameter int WIDTH = glip_pkg::GLIP_WIDTH
);
    import glip_pkg::*;

    logic [WIDTH-1:0]      host_in_data;
    logic                  host_in_valid;
    logic                  host_in_ready;
    logic [WIDTH-1:0]      host_out_data;
    logic                  host_out_valid;
    logic                  host_out_ready;
    logic                  host_ctrl_valid;
    logic [CTRL_WIDTH-1:0] host_ctrl_data;
    logic [WIDTH-1:0]      fifo_in_data;
    logic                  fifo_in_valid;
    logic                  fifo_in_ready;
    logic [WIDTH-1:0]      fifo_out_data;
    logic                  fifo_out_valid;
    logic                  fifo_out_ready;
    logic                  com_rst;
    logic                  logic_rst;

    modport slave (
        input  host_in_data, host_in_valid, host_out_ready,
        input  host_ctrl_valid, host_ctrl_data,
        input  fifo_in_ready, fifo_out_data, fifo_out_valid,
        output host_in_ready, host_out_data, host_out_valid,
        output fifo_in_data, fifo_in_valid, fifo_out_ready,
        output com_rst, logic_rst
    );

    modport master (
        output host_in_data, host_in_valid, host_out_ready,
        output host_ctrl_valid, host_ctrl_data,
        output fifo_in_ready, fifo_out_data, fifo_out_valid,
        input  host_in_ready, host_out_data, host_out_valid,
        input  fifo_in_data, fifo_in_valid, fifo_out_ready,
        input  com_rst, logic_rst
    );

endinterface

// File: rtl/glip_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers and a flush input.
// A word pushed on one edge is presented on pop_data from the following cycle.
module glip_sync_fifo
    import glip_pkg::*;
#(
    parameter int WIDTH = GLIP_WIDTH,
    parameter int DEPTH = GLIP_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = fifo_ptr_width(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same slot with opposite wrap bits means the writer has lapped the reader
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    // A full FIFO refuses a push even when a pop frees a slot on the same edge
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are meaningful, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/glip_host_bridge.sv
// GLIP host<->logic bridge: one FIFO per direction plus the host control register
// that drives the held logic_rst level and the one-cycle com_rst link flush.
module glip_host_bridge
    import glip_pkg::*;
#(
    parameter int WIDTH      = GLIP_WIDTH,
    parameter int FIFO_DEPTH = GLIP_FIFO_DEPTH
) (
    input logic               clk,
    input logic               rst,
    glip_host_bridge_if.slave bus
);

    ctrl_word_t ctrl_word;
    logic       flush;
    logic       in_full;
    logic       in_empty;
    logic       out_full;
    logic       out_empty;
    logic       logic_rst_q;
    logic       com_rst_q;

    assign ctrl_word = ctrl_word_t'(bus.host_ctrl_data);

    // A com_rst request empties both directions on the same edge it is written
    assign flush = bus.host_ctrl_valid && ctrl_word.com_rst;

    glip_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.host_in_valid),
        .push_data (bus.host_in_data),
        .pop       (bus.fifo_in_ready),
        .flush     (flush),
        .pop_data  (bus.fifo_in_data),
        .full      (in_full),
        .empty     (in_empty)
    );

    glip_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.fifo_out_valid),
        .push_data (bus.fifo_out_data),
        .pop       (bus.host_out_ready),
        .flush     (flush),
        .pop_data  (bus.host_out_data),
        .full      (out_full),
        .empty     (out_empty)
    );

    assign bus.host_in_ready  = !in_full;
    assign bus.fifo_in_valid  = !in_empty;
    assign bus.fifo_out_ready = !out_full;
    assign bus.host_out_valid = !out_empty;

    // rst is checked first so a control write in a reset cycle has no effect
    always_ff @(posedge clk) begin
        if (rst) begin
            logic_rst_q <= 1'b0;
            com_rst_q   <= 1'b0;
        end else begin
            com_rst_q <= flush;
            if (bus.host_ctrl_valid) logic_rst_q <= ctrl_word.logic_rst;
        end
    end

    assign bus.logic_rst = logic_rst_q;
    assign bus.com_rst   = com_rst_q;

endmodule

// File: tb/tb_glip_host_bridge.sv
// Directed and randomized bench for glip_host_bridge against a queue-based model
// of both stream directions and the control register.
module tb_glip_host_bridge;
    import glip_pkg::*;

    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    glip_host_bridge_if #(.WIDTH(W)) bus ();

    glip_host_bridge #(
        .WIDTH      (W),
        .FIFO_DEPTH (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: one queue per direction plus expected control outputs
    logic [W-1:0] in_q[$];
    logic [W-1:0] out_q[$];
    logic         exp_logic_rst = 1'b0;
    logic         exp_com_rst   = 1'b0;
    int           in_rx;
    int           out_rx;
    bit           in_acc;
    bit           out_acc;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Compare DUT against the model, advance the model by one edge, then step the clock
    task automatic cycle();
        bit in_pop;
        bit out_pop;
        bit flush;
        check("host_in_ready",  32'(bus.host_in_ready),  32'(in_q.size() < D));
        check("fifo_in_valid",  32'(bus.fifo_in_valid),  32'(in_q.size() != 0));
        if (in_q.size() != 0) check("fifo_in_data", 32'(bus.fifo_in_data), 32'(in_q[0]));
        check("fifo_out_ready", 32'(bus.fifo_out_ready), 32'(out_q.size() < D));
        check("host_out_valid", 32'(bus.host_out_valid), 32'(out_q.size() != 0));
        if (out_q.size() != 0) check("host_out_data", 32'(bus.host_out_data), 32'(out_q[0]));
        check("logic_rst", 32'(bus.logic_rst), 32'(exp_logic_rst));
        check("com_rst",   32'(bus.com_rst),   32'(exp_com_rst));

        in_acc  = bus.host_in_valid  && (in_q.size()  < D);
        out_acc = bus.fifo_out_valid && (out_q.size() < D);
        in_pop  = bus.fifo_in_ready  && (in_q.size()  != 0);
        out_pop = bus.host_out_ready && (out_q.size() != 0);
        flush   = bus.host_ctrl_valid && bus.host_ctrl_data[CTRL_COM_RST];

        if (bus.host_ctrl_valid) exp_logic_rst = bus.host_ctrl_data[CTRL_LOGIC_RST];
        exp_com_rst = flush;
        if (flush) begin
            in_q.delete();
            out_q.delete();
            in_acc  = 1'b0;
            out_acc = 1'b0;
        end else begin
            if (in_pop) begin
                void'(in_q.pop_front());
                in_rx++;
            end
            if (out_pop) begin
                void'(out_q.pop_front());
                out_rx++;
            end
            if (in_acc)  in_q.push_back(bus.host_in_data);
            if (out_acc) out_q.push_back(bus.fifo_out_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int in_tx;
        int out_tx;
        int base;
        bit got;

        bus.host_in_data    = '0;
        bus.host_in_valid   = 1'b0;
        bus.host_out_ready  = 1'b0;
        bus.host_ctrl_valid = 1'b0;
        bus.host_ctrl_data  = '0;
        bus.fifo_in_ready   = 1'b0;
        bus.fifo_out_data   = '0;
        bus.fifo_out_valid  = 1'b0;
        in_rx  = 0;
        out_rx = 0;

        // Reset for two cycles with a control write pending: reset must win
        rst = 1'b1;
        bus.host_ctrl_valid = 1'b1;
        bus.host_ctrl_data  = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.host_ctrl_valid = 1'b0;
        bus.host_ctrl_data  = 2'b00;
        check("rst_host_in_ready",  32'(bus.host_in_ready),  32'd1);
        check("rst_fifo_out_ready", 32'(bus.fifo_out_ready), 32'd1);
        check("rst_fifo_in_valid",  32'(bus.fifo_in_valid),  32'd0);
        check("rst_host_out_valid", 32'(bus.host_out_valid), 32'd0);
        check("rst_logic_rst",      32'(bus.logic_rst),      32'd0);
        check("rst_com_rst",        32'(bus.com_rst),        32'd0);

        // Host stream: three words with the system always ready
        bus.fifo_in_ready = 1'b1;
        bus.host_in_valid = 1'b1;
        bus.host_in_data  = 16'h1111;
        cycle();
        check("first_word_latency", 32'(bus.fifo_in_valid), 32'd1);
        check("first_word_data",    32'(bus.fifo_in_data),  32'h1111);
        bus.host_in_data = 16'h2222;
        cycle();
        bus.host_in_data = 16'h3333;
        cycle();
        bus.host_in_valid = 1'b0;
        repeat (3) cycle();
        check("stream_count", 32'(in_rx), 32'd3);

        // Backpressure: eight words fill the FIFO, the ninth must be held
        base = in_rx;
        bus.fifo_in_ready = 1'b0;
        bus.host_in_valid = 1'b1;
        for (int i = 0; i < D; i++) begin
            bus.host_in_data = 16'h5000 + 16'(i);
            cycle();
        end
        bus.host_in_data = 16'h5008;
        check("full_ready_low", 32'(bus.host_in_ready), 32'd0);
        repeat (3) cycle();
        check("full_no_accept", 32'(in_acc), 32'd0);
        bus.fifo_in_ready = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            cycle();
            got = in_acc;
        end
        check("ninth_accepted", 32'(got), 32'd1);
        bus.host_in_valid = 1'b0;
        repeat (12) cycle();
        check("full_all_arrived", 32'(in_rx - base), 32'd9);

        // Reverse path with host_out_ready toggling
        base = out_rx;
        bus.host_out_ready = 1'b0;
        bus.fifo_out_valid = 1'b1;
        bus.fifo_out_data  = 16'hABCD;
        cycle();
        bus.fifo_out_data  = 16'h0001;
        cycle();
        bus.fifo_out_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.host_out_ready = (i % 2) == 1;
            cycle();
        end
        check("reverse_count", 32'(out_rx - base), 32'd2);

        // Control: hold logic_rst, then flush with words queued both ways
        bus.host_ctrl_valid = 1'b1;
        bus.host_ctrl_data  = 2'b01;
        cycle();
        bus.host_ctrl_valid = 1'b0;
        check("logic_rst_set", 32'(bus.logic_rst), 32'd1);
        bus.fifo_in_ready  = 1'b0;
        bus.host_out_ready = 1'b0;
        bus.host_in_valid  = 1'b1;
        bus.fifo_out_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.host_in_data  = 16'h7000 + 16'(i);
            bus.fifo_out_data = 16'h8000 + 16'(i);
            cycle();
        end
        check("logic_rst_held", 32'(bus.logic_rst), 32'd1);
        bus.fifo_out_valid  = 1'b0;
        bus.host_in_data    = 16'hDEAD;
        bus.host_ctrl_valid = 1'b1;
        bus.host_ctrl_data  = 2'b10;
        cycle();
        bus.host_ctrl_valid = 1'b0;
        bus.host_in_valid   = 1'b0;
        check("flush_com_rst",    32'(bus.com_rst),        32'd1);
        check("flush_logic_rst",  32'(bus.logic_rst),      32'd0);
        check("flush_in_empty",   32'(bus.fifo_in_valid),  32'd0);
        check("flush_out_empty",  32'(bus.host_out_valid), 32'd0);
        cycle();
        check("com_rst_one_cycle", 32'(bus.com_rst), 32'd0);

        // Randomized traffic in both directions, long enough to wrap the pointers
        in_tx  = 0;
        out_tx = 0;
        in_rx  = 0;
        out_rx = 0;
        for (int cyc = 0; cyc < 3000 && (in_rx < 100 || out_rx < 100); cyc++) begin
            if (!bus.host_in_valid && in_tx < 100 && $urandom_range(0, 1) == 1) begin
                bus.host_in_valid = 1'b1;
                bus.host_in_data  = 16'($urandom);
            end
            if (!bus.fifo_out_valid && out_tx < 100 && $urandom_range(0, 1) == 1) begin
                bus.fifo_out_valid = 1'b1;
                bus.fifo_out_data  = 16'($urandom);
            end
            bus.fifo_in_ready  = $urandom_range(0, 1) == 1;
            bus.host_out_ready = $urandom_range(0, 1) == 1;
            cycle();
            if (in_acc) begin
                in_tx++;
                bus.host_in_valid = 1'b0;
            end
            if (out_acc) begin
                out_tx++;
                bus.fifo_out_valid = 1'b0;
            end
        end
        check("random_in_count",  32'(in_rx),  32'd100);
        check("random_out_count", 32'(out_rx), 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
